// File: rtl/cu_pkg.sv
// =============================================================================
// cu_pkg : shared constants for the SAP-style control unit (opcodes, ctrl bits)
// Rev 1.0
// =============================================================================
`default_nettype none

package cu_pkg;

  localparam int STEP_W = 3;
  localparam int CTRL_W = 16;

  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef logic [STEP_W-1:0] step_t;

  localparam step_t T0 = 3'd0;
  localparam step_t T1 = 3'd1;
  localparam step_t T2 = 3'd2;
  localparam step_t T3 = 3'd3;
  localparam step_t T4 = 3'd4;

  // Bit positions inside the control word, MSB first: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
  typedef enum int {
    CB_FI  = 0,  CB_J   = 1,  CB_CO  = 2,  CB_CE  = 3,
    CB_OI  = 4,  CB_BI  = 5,  CB_SU  = 6,  CB_EO  = 7,
    CB_AO  = 8,  CB_AI  = 9,  CB_II  = 10, CB_IO  = 11,
    CB_RO  = 12, CB_RI  = 13, CB_MI  = 14, CB_HLT = 15
  } ctrl_bit_e;

  localparam ctrl_t C_HLT = ctrl_t'(1) << CB_HLT;
  localparam ctrl_t C_MI  = ctrl_t'(1) << CB_MI;
  localparam ctrl_t C_RI  = ctrl_t'(1) << CB_RI;
  localparam ctrl_t C_RO  = ctrl_t'(1) << CB_RO;
  localparam ctrl_t C_IO  = ctrl_t'(1) << CB_IO;
  localparam ctrl_t C_II  = ctrl_t'(1) << CB_II;
  localparam ctrl_t C_AI  = ctrl_t'(1) << CB_AI;
  localparam ctrl_t C_AO  = ctrl_t'(1) << CB_AO;
  localparam ctrl_t C_EO  = ctrl_t'(1) << CB_EO;
  localparam ctrl_t C_SU  = ctrl_t'(1) << CB_SU;
  localparam ctrl_t C_BI  = ctrl_t'(1) << CB_BI;
  localparam ctrl_t C_OI  = ctrl_t'(1) << CB_OI;
  localparam ctrl_t C_CE  = ctrl_t'(1) << CB_CE;
  localparam ctrl_t C_CO  = ctrl_t'(1) << CB_CO;
  localparam ctrl_t C_J   = ctrl_t'(1) << CB_J;
  localparam ctrl_t C_FI  = ctrl_t'(1) << CB_FI;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

`default_nettype wire

// File: rtl/microcode_rom.sv
// =============================================================================
// microcode_rom : combinational decode {opcode, step, C, Z} -> control word
// Rev 1.0
// =============================================================================
`default_nettype none

module microcode_rom
  import cu_pkg::*;
(
  input  logic [3:0]        opcode_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              carry_i,
  input  logic              zero_i,
  output logic [CTRL_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    case (step_i)
      T0: word_o = C_CO | C_MI;
      T1: word_o = C_RO | C_II | C_CE;
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: word_o = C_IO | C_MI;
          OP_LDI: word_o = C_IO | C_AI;
          OP_JMP: word_o = C_IO | C_J;
          OP_JC:  word_o = carry_i ? (C_IO | C_J) : '0;
          OP_JZ:  word_o = zero_i  ? (C_IO | C_J) : '0;
          OP_OUT: word_o = C_AO | C_OI;
          OP_HLT: word_o = C_HLT;
          default: word_o = '0;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: word_o = C_RO | C_AI;
          OP_ADD, OP_SUB: word_o = C_RO | C_BI;
          OP_STA: word_o = C_AO | C_RI;
          default: word_o = '0;
        endcase
      end
      T4: begin
        case (opcode_i)
          OP_ADD: word_o = C_EO | C_AI | C_FI;
          OP_SUB: word_o = C_EO | C_AI | C_FI | C_SU;
          default: word_o = '0;
        endcase
      end
      default: word_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// =============================================================================
// control_unit : IR, microstep counter, flags and halt latch driving the ROM
// Rev 1.0
// =============================================================================
`default_nettype none

module control_unit
  import cu_pkg::*;
#(
  parameter int EARLY_END = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_en,
  input  logic [7:0]  bus_in,
  input  logic        carry_in,
  input  logic        zero_in,
  output logic [15:0] ctrl,
  output logic [3:0]  bus_out,
  output logic        bus_oe,
  output logic [7:0]  ir,
  output logic [2:0]  step,
  output logic [1:0]  flags,
  output logic        halted
);

  logic [7:0]        ir_q,     ir_d;
  logic [STEP_W-1:0] step_q,   step_d;
  logic [1:0]        flags_q,  flags_d;
  logic              halted_q, halted_d;

  logic [CTRL_W-1:0] rom_word;
  logic [CTRL_W-1:0] nxt_word;
  logic [STEP_W-1:0] step_inc;

  assign step_inc = step_q + STEP_W'(1);

  microcode_rom u_rom_cur (
    .opcode_i (ir_q[7:4]),
    .step_i   (step_q),
    .carry_i  (flags_q[1]),
    .zero_i   (flags_q[0]),
    .word_o   (rom_word)
  );

  // Lookahead decode of the following step, used only to cut instructions short
  microcode_rom u_rom_nxt (
    .opcode_i (ir_q[7:4]),
    .step_i   (step_inc),
    .carry_i  (flags_q[1]),
    .zero_i   (flags_q[0]),
    .word_o   (nxt_word)
  );

  assign ctrl    = halted_q ? C_HLT : rom_word;
  assign bus_oe  = ctrl[CB_IO];
  assign bus_out = ir_q[3:0];
  assign ir      = ir_q;
  assign step    = step_q;
  assign flags   = flags_q;
  assign halted  = halted_q;

  always_comb begin
    ir_d     = ir_q;
    step_d   = step_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    if (step_en && !halted_q) begin
      // The halting edge keeps the step so the frozen state still shows T2
      if (ctrl[CB_HLT]) begin
        halted_d = 1'b1;
      end else if ((step_q == T4) ||
                   ((EARLY_END != 0) && (step_q >= T2) && (nxt_word == '0))) begin
        step_d = T0;
      end else begin
        step_d = step_inc;
      end
      if (ctrl[CB_II]) ir_d    = bus_in;
      if (ctrl[CB_FI]) flags_d = {carry_in, zero_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= '0;
      step_q   <= T0;
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      step_q   <= step_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// =============================================================================
// tb_control_unit : random + directed bench for both EARLY_END settings
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_control_unit;

  localparam logic [15:0] HLT_M = 16'h8000, MI_M = 16'h4000, RI_M = 16'h2000, RO_M = 16'h1000;
  localparam logic [15:0] IO_M  = 16'h0800, II_M = 16'h0400, AI_M = 16'h0200, AO_M = 16'h0100;
  localparam logic [15:0] EO_M  = 16'h0080, SU_M = 16'h0040, BI_M = 16'h0020, OI_M = 16'h0010;
  localparam logic [15:0] CE_M  = 16'h0008, CO_M = 16'h0004, J_M  = 16'h0002, FI_M = 16'h0001;

  logic        clk = 1'b0;
  logic        rst_n, step_en, carry_in, zero_in;
  logic [7:0]  bus_in;

  logic [15:0] ctrl0, ctrl1;
  logic [3:0]  bo0, bo1;
  logic        oe0, oe1, h0, h1;
  logic [7:0]  ir0, ir1;
  logic [2:0]  st0, st1;
  logic [1:0]  fl0, fl1;

  always #5 clk = ~clk;

  control_unit #(.EARLY_END(1)) u_dut_early (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .bus_in(bus_in),
    .carry_in(carry_in), .zero_in(zero_in), .ctrl(ctrl0), .bus_out(bo0),
    .bus_oe(oe0), .ir(ir0), .step(st0), .flags(fl0), .halted(h0)
  );

  control_unit #(.EARLY_END(0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .bus_in(bus_in),
    .carry_in(carry_in), .zero_in(zero_in), .ctrl(ctrl1), .bus_out(bo1),
    .bus_oe(oe1), .ir(ir1), .step(st1), .flags(fl1), .halted(h1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: index 0 = early-end machine, index 1 = fixed five-step machine
  int         m_step [2];
  logic [7:0] m_ir   [2];
  logic       m_c    [2];
  logic       m_z    [2];
  logic       m_h    [2];

  function automatic logic [15:0] uword(input logic [3:0] op, input int t, input logic c, input logic z);
    if (t == 0) return CO_M | MI_M;
    if (t == 1) return RO_M | II_M | CE_M;
    case (op)
      4'h1: return (t == 2) ? (IO_M | MI_M) : (t == 3) ? (RO_M | AI_M) : 16'h0;
      4'h2: return (t == 2) ? (IO_M | MI_M) : (t == 3) ? (RO_M | BI_M) :
                   (t == 4) ? (EO_M | AI_M | FI_M) : 16'h0;
      4'h3: return (t == 2) ? (IO_M | MI_M) : (t == 3) ? (RO_M | BI_M) :
                   (t == 4) ? (EO_M | AI_M | FI_M | SU_M) : 16'h0;
      4'h4: return (t == 2) ? (IO_M | MI_M) : (t == 3) ? (AO_M | RI_M) : 16'h0;
      4'h5: return (t == 2) ? (IO_M | AI_M) : 16'h0;
      4'h6: return (t == 2) ? (IO_M | J_M) : 16'h0;
      4'h7: return (t == 2 && c) ? (IO_M | J_M) : 16'h0;
      4'h8: return (t == 2 && z) ? (IO_M | J_M) : 16'h0;
      4'hE: return (t == 2) ? (AO_M | OI_M) : 16'h0;
      4'hF: return (t == 2) ? HLT_M : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] model_ctrl(input int k);
    if (m_h[k]) return HLT_M;
    return uword(m_ir[k][7:4], m_step[k], m_c[k], m_z[k]);
  endfunction

  task automatic model_edge(input int k, input bit early);
    logic [15:0] w;
    int ns;
    if (m_h[k]) return;
    w = model_ctrl(k);
    if ((w & HLT_M) != 0) begin
      m_h[k] = 1'b1;
      return;
    end
    ns = (m_step[k] + 1) % 5;
    if (early && m_step[k] >= 2 && uword(m_ir[k][7:4], m_step[k] + 1, m_c[k], m_z[k]) == 16'h0)
      ns = 0;
    if ((w & II_M) != 0) m_ir[k] = bus_in;
    if ((w & FI_M) != 0) begin
      m_c[k] = carry_in;
      m_z[k] = zero_in;
    end
    m_step[k] = ns;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_step[k] = 0; m_ir[k] = 8'h00; m_c[k] = 1'b0; m_z[k] = 1'b0; m_h[k] = 1'b0;
    end
  endtask

  task automatic compare_all(input string where);
    for (int k = 0; k < 2; k++) begin
      logic [15:0] ec;
      ec = model_ctrl(k);
      check($sformatf("%s.%0d.ctrl", where, k),   (k == 0) ? ctrl0 : ctrl1, ec);
      check($sformatf("%s.%0d.step", where, k),   (k == 0) ? st0 : st1, m_step[k]);
      check($sformatf("%s.%0d.ir", where, k),     (k == 0) ? ir0 : ir1, m_ir[k]);
      check($sformatf("%s.%0d.flags", where, k),  (k == 0) ? fl0 : fl1, {m_c[k], m_z[k]});
      check($sformatf("%s.%0d.halted", where, k), (k == 0) ? h0 : h1, m_h[k]);
      check($sformatf("%s.%0d.busout", where, k), (k == 0) ? bo0 : bo1, m_ir[k][3:0]);
      check($sformatf("%s.%0d.busoe", where, k),  (k == 0) ? oe0 : oe1, (ec & IO_M) != 0);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the following edge
  task automatic cycle(input logic en);
    step_en = en;
    @(posedge clk);
    if (en) begin
      model_edge(0, 1'b1);
      model_edge(1, 1'b0);
    end
    #1;
    compare_all("cyc");
  endtask

  // Asynchronous reset pulse placed well away from any clock edge
  task automatic areset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all("rst");
    #1 rst_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] b, input logic c, input logic z);
    bus_in = b; carry_in = c; zero_in = z;
  endtask

  initial begin
    int exp0 [5];
    int exp1 [5];
    rst_n = 1'b0; step_en = 1'b0;
    load(8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("por");
    check("por_ctrl", ctrl0, CO_M | MI_M);
    #2 rst_n = 1'b1;

    // LDI 1: fetch words then operand load
    load(8'h51, 1'b0, 1'b0);
    cycle(1'b1);
    check("t1_ctrl", ctrl0, RO_M | II_M | CE_M);
    cycle(1'b1);
    check("ldi_ir", ir0, 8'h51);
    check("ldi_t2", ctrl0, IO_M | AI_M);
    check("ldi_busout", bo0, 4'h1);
    cycle(1'b1);
    check("ldi_end", st0, 3'd0);
    repeat (3) cycle(1'b0);

    // ADD then JC taken
    areset();
    load(8'h2E, 1'b1, 1'b0);
    cycle(1'b1); cycle(1'b1);
    check("add_t2", ctrl0, IO_M | MI_M);
    cycle(1'b1);
    check("add_t3", ctrl0, RO_M | BI_M);
    cycle(1'b1);
    check("add_t4", ctrl0, EO_M | AI_M | FI_M);
    cycle(1'b1);
    check("add_flags", fl0, 2'b10);
    check("add_end", st0, 3'd0);
    load(8'h70, 1'b0, 1'b1);
    cycle(1'b1); cycle(1'b1);
    check("jc_c1", ctrl0, IO_M | J_M);

    // SUB giving C=0 Z=1, then JC not taken and JZ taken
    areset();
    load(8'h3E, 1'b0, 1'b1);
    repeat (4) cycle(1'b1);
    check("sub_t4", ctrl0, EO_M | AI_M | FI_M | SU_M);
    cycle(1'b1);
    check("sub_flags", fl0, 2'b01);
    load(8'h70, 1'b1, 1'b0);
    cycle(1'b1); cycle(1'b1);
    check("jc_c0", ctrl0, 16'h0000);
    cycle(1'b1);
    load(8'h80, 1'b1, 1'b0);
    cycle(1'b1); cycle(1'b1);
    check("jz_z1", ctrl0, IO_M | J_M);

    // HLT freezes everything until reset
    areset();
    load(8'hF0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1);
    check("hlt_set", h0, 1'b1);
    check("hlt_step", st0, 3'd2);
    repeat (10) cycle(1'b1);
    check("hlt_frozen_step", st0, 3'd2);
    check("hlt_frozen_ctrl", ctrl0, HLT_M);
    areset();
    check("hlt_rst_ctrl", ctrl0, CO_M | MI_M);
    check("hlt_rst_h", h0, 1'b0);

    // NOP step sequences
    load(8'h00, 1'b0, 1'b0);
    exp0 = '{1, 2, 0, 1, 2};
    exp1 = '{1, 2, 3, 4, 0};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      check($sformatf("nop_early_%0d", i), st0, exp0[i]);
      check($sformatf("nop_full_%0d", i), st1, exp1[i]);
    end

    // STA aborted by reset at T3
    areset();
    load(8'h4A, 1'b0, 1'b0);
    repeat (3) cycle(1'b1);
    check("sta_ri_t3", ctrl0[13], 1'b1);
    areset();
    check("sta_abort_ri", ctrl0[13], 1'b0);
    check("sta_abort_ir", ir0, 8'h00);
    load(8'h00, 1'b0, 1'b0);
    repeat (4) cycle(1'b1);

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 47) == 0) areset();
      load(8'($urandom), 1'($urandom), 1'($urandom));
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
